tensor_core_arbiter: RTL and testbench
======================================

# tensor_core_arbiter

Shares one tensor core sequencer (2x2 systolic array fed by alternating A/B words) between `NUM_REQ` requesters. Accepts jobs over a valid/ready handshake, arbitrates round-robin, validates matrix size, issues the core start pulse and routes the owner's A/B word stream to the core. It detects job completion from the core's `valid`, counts result tiles, and returns a done/err response. An optional watchdog aborts hung jobs by resetting the core.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8)
- `MAX_SIZE`, 64: largest accepted matrix dimension
- `WDOG_LIMIT`, 65535: watchdog cycle limit; used only with the macro
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  job request per requester
- `req_ready`  out  NUM_REQ  job accepted this cycle
- `req_size`  in  NUM_REQ*17  signed matrix dimension per requester
- `req_inA`, `req_inB`  in  NUM_REQ*32 each  packed 2x2 int8 blocks: [31:24]=11, [23:16]=12, [15:8]=21, [7:0]=22
- `gnt`  out  NUM_REQ  owner is streaming; at most one bit high
- `done`  out  NUM_REQ  one-cycle response pulse
- `err`  out  1  error qualifier; valid with any `done` bit
- `tiles`  out  32  push22 count for the job; valid with `done`
- `core_start`  out  1  one-cycle start to core
- `core_size`  out  17  latched size of the current job
- `core_inA`, `core_inB`  out  32 each  owner's words while `gnt`, else 0
- `core_valid`  in  1  core completion flag (level; cleared by core one cycle after start)
- `core_push22`  in  1  core tile-complete pulse
- `core_reset`  out  1  active-high synchronous reset to core

## Operation
- States: IDLE, START, WAIT_CLR, WAIT_DONE, RESP, plus ABORT (macro only).
- IDLE:
  - Round-robin pick among `req_valid`, searching from `last+1`. `last` resets to NUM_REQ-1, so requester 0 wins first.
  - Winner gets combinational `req_ready`; handshake is `req_valid & req_ready`.
  - Latch `owner` and `size`.
  - Size is valid iff even, `>=2` and `<=MAX_SIZE`. Valid goes to START; invalid goes to RESP with err=1 and tiles=0.
- START: `core_start=1` for one cycle; clear the tile counter; go to WAIT_CLR.
- WAIT_CLR: `gnt[owner]=1`; hold until `core_valid==0`, then go to WAIT_DONE. This covers `valid` still high from the previous job.
- WAIT_DONE: `gnt[owner]=1`; count `core_push22`; on `core_valid==1` go to RESP.
- RESP: `done[owner]=1`; drive `err` and `tiles`; set `last=owner`; go to IDLE.
- ABORT: `core_reset=1` for one cycle; go to RESP with err=1 and tiles at the partial count.
- Data path:
  - `core_inA/inB` are combinational muxes of the owner's words, gated by `gnt`.
  - Requesters present A in the first `gnt` cycle and alternate A/B every cycle; the arbiter applies no backpressure.
- Requesters hold `req_valid` and `req_size` stable until accepted. Dropping `req_valid` before acceptance is legal.
- Requests arriving while busy wait; `req_ready` is 0 outside IDLE.
- `tiles` saturates at 2^32-1.

## Timing
- Reset values:
  - State IDLE; `last=NUM_REQ-1`.
  - `req_ready`, `gnt`, `done`, `err`, `tiles`, `core_start`, `core_size`, `core_inA/inB` are 0.
  - `core_reset=1` while `reset==0`.
- Cycle 0 accept; cycle 1 `core_start`; cycle 2 first `gnt` cycle, which is the core's first shift cycle.
- Response arrives 1 cycle after `core_valid` is seen high in WAIT_DONE.
- Earliest next accept is the cycle after RESP (IDLE); the core is already in its idle state by then.
- Invalid size: accept at cycle 0, `done`+`err` at cycle 1.
- Reset mid-job: immediate return to IDLE, `core_reset` asserted, no response pulse.
- `core_push22` coinciding with `core_valid` in WAIT_DONE is counted.

## Configuration
- `TENSOR_ARB_WDOG_EN` defined:
  - A 32-bit counter runs in WAIT_CLR/WAIT_DONE and clears in START.
  - Reaching `WDOG_LIMIT` goes to ABORT.
- Undefined:
  - No counter and no ABORT state.
  - `core_reset = ~reset` only; `err` only flags an invalid size.

## Structure
- `tensor_pkg`: `arb_state_t` enum, `SIZE_W=17`, `WORD_W=32`, `TILE_W=32`.
- Sub-module `rr_picker`: combinational round-robin one-hot select from request vector and `last` index.

## Test plan
- Size 4 from requester 0 with core model → `core_start` at cycle 1, `gnt[0]` from cycle 2, `done[0]` with err=0 and tiles=4.
- Size 2 → tiles=1, err=0; `core_valid` still high from the previous job does not cause early completion.
- `req_valid=2'b11` simultaneously after reset → requester 0 served, then requester 1; next pair → 0 again.
- Sizes 3, 0, -2 and 66 (MAX_SIZE=64) → immediate `done` with err=1, tiles=0, `core_start` never asserted.
- Watchdog on, WDOG_LIMIT=20, core never raises `valid` → `core_reset` pulse at limit, then `done` with err=1.
- `reset` low during WAIT_DONE → `gnt`=0, no `done`, `core_reset`=1; after release, a new job completes normally.

Source files
------------

// File: rtl/tensor_pkg.sv
// Shared types and widths for the tensor core arbiter.
// TENSOR_ARB_WDOG_EN adds the ABORT state used by the job watchdog.
package tensor_pkg;

  localparam int SIZE_W = 17;
  localparam int WORD_W = 32;
  localparam int TILE_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_CLR,
    ST_WAIT_DONE,
    ST_RESP
`ifdef TENSOR_ARB_WDOG_EN
    , ST_ABORT
`endif
  } arb_state_t;

  // A job is runnable only for an even dimension in [2, max_size].
  function automatic logic size_ok(input logic signed [SIZE_W-1:0] size,
                                   input int max_size);
    int sz;
    sz = int'(size);
    return (size[0] == 1'b0) && (sz >= 2) && (sz <= max_size);
  endfunction

endpackage

// File: rtl/tensor_core_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot winner searching upward from last+1.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  pick_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!any_o && req_i[j] && (j == ((int'(last_i) + k) % N))) begin
          any_o     = 1'b1;
          pick_o[j] = 1'b1;
          idx_o     = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/tensor_core_arbiter.sv
// Shares one 2x2 tensor core sequencer between NUM_REQ requesters.
// Optional job watchdog enabled by defining TENSOR_ARB_WDOG_EN.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | pick a requester, accept its job, check the size
// ST_START     | one-cycle core_start, clear tile counter
// ST_WAIT_CLR  | owner streams; wait for stale core_valid to drop
// ST_WAIT_DONE | owner streams; count push22 until core_valid rises
// ST_RESP      | one-cycle done/err/tiles response to the owner
// ST_ABORT     | watchdog fired: one-cycle core_reset (macro only)
module tensor_core_arbiter
  import tensor_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int MAX_SIZE   = 64,
  parameter int WDOG_LIMIT = 65535
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*SIZE_W-1:0] req_size,
  input  logic [NUM_REQ*WORD_W-1:0] req_inA,
  input  logic [NUM_REQ*WORD_W-1:0] req_inB,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [TILE_W-1:0]         tiles,
  output logic                      core_start,
  output logic [SIZE_W-1:0]         core_size,
  output logic [WORD_W-1:0]         core_inA,
  output logic [WORD_W-1:0]         core_inB,
  input  logic                      core_valid,
  input  logic                      core_push22,
  output logic                      core_reset
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_LIMIT < 1) begin : g_cfg_check
    $error("tensor_core_arbiter: unsupported parameter set");
  end

  arb_state_t          state_q;
  logic [IW-1:0]       owner_q;
  logic [IW-1:0]       last_q;
  logic [SIZE_W-1:0]   size_q;
  logic [TILE_W-1:0]   cnt_q;
  logic [TILE_W-1:0]   cnt_d;
  logic [TILE_W-1:0]   cnt_sat;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  done_q;
  logic                err_q;
  logic [TILE_W-1:0]   tiles_q;
  logic                start_q;
  logic [NUM_REQ-1:0]  owner_oh;

  logic [NUM_REQ-1:0]  pick;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic [SIZE_W-1:0]   pick_size;

`ifdef TENSOR_ARB_WDOG_EN
  logic [31:0]         wdog_q;
  logic                wdog_hit;
  assign wdog_hit = (wdog_q + 32'd1) == 32'(WDOG_LIMIT);
`endif

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .req_i  (req_valid),
    .last_i (last_q),
    .pick_o (pick),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign pick_size = req_size[pick_idx*SIZE_W +: SIZE_W];
  assign owner_oh  = NUM_REQ'(1) << owner_q;

  // Tile counter saturates rather than wrapping on very long jobs.
  assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + TILE_W'(1);
  assign cnt_d   = core_push22 ? cnt_sat : cnt_q;

  assign req_ready  = (state_q == ST_IDLE) ? pick : '0;
  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign tiles      = tiles_q;
  assign core_start = start_q;
  assign core_size  = size_q;
  assign core_inA   = (|gnt_q) ? req_inA[owner_q*WORD_W +: WORD_W] : '0;
  assign core_inB   = (|gnt_q) ? req_inB[owner_q*WORD_W +: WORD_W] : '0;

`ifdef TENSOR_ARB_WDOG_EN
  assign core_reset = ~reset | (state_q == ST_ABORT);
`else
  assign core_reset = ~reset;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      size_q  <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      tiles_q <= '0;
      start_q <= 1'b0;
`ifdef TENSOR_ARB_WDOG_EN
      wdog_q  <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            owner_q <= pick_idx;
            size_q  <= pick_size;
            if (size_ok(pick_size, MAX_SIZE)) begin
              state_q <= ST_START;
              start_q <= 1'b1;
            end else begin
              state_q <= ST_RESP;
              done_q  <= pick;
              err_q   <= 1'b1;
              tiles_q <= '0;
            end
          end
        end
        ST_START: begin
          cnt_q   <= '0;
          gnt_q   <= owner_oh;
          state_q <= ST_WAIT_CLR;
`ifdef TENSOR_ARB_WDOG_EN
          wdog_q  <= '0;
`endif
        end
        ST_WAIT_CLR: begin
          if (!core_valid) state_q <= ST_WAIT_DONE;
`ifdef TENSOR_ARB_WDOG_EN
          wdog_q <= wdog_q + 32'd1;
          if (wdog_hit) begin
            state_q <= ST_ABORT;
            gnt_q   <= '0;
          end
`endif
        end
        ST_WAIT_DONE: begin
          cnt_q <= cnt_d;
`ifdef TENSOR_ARB_WDOG_EN
          wdog_q <= wdog_q + 32'd1;
          if (wdog_hit) begin
            state_q <= ST_ABORT;
            gnt_q   <= '0;
          end
`endif
          // Completion wins over a watchdog hit in the same cycle.
          if (core_valid) begin
            state_q <= ST_RESP;
            gnt_q   <= '0;
            done_q  <= owner_oh;
            err_q   <= 1'b0;
            tiles_q <= cnt_d;
          end
        end
`ifdef TENSOR_ARB_WDOG_EN
        ST_ABORT: begin
          state_q <= ST_RESP;
          done_q  <= owner_oh;
          err_q   <= 1'b1;
          tiles_q <= cnt_q;
        end
`endif
        ST_RESP: begin
          last_q  <= owner_q;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_core_arbiter.sv
// Directed bench for tensor_core_arbiter with a cycle-scripted core model.
module tb_tensor_core_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [33:0] req_size;
  logic [63:0] req_inA;
  logic [63:0] req_inB;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic        err;
  logic [31:0] tiles;
  logic        core_start;
  logic [16:0] core_size;
  logic [31:0] core_inA;
  logic [31:0] core_inB;
  logic        core_valid;
  logic        core_push22;
  logic        core_reset;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A0 = 32'h1112_2122;
  localparam logic [31:0] B0 = 32'h5566_7788;
  localparam logic [31:0] A1 = 32'hB0B1_B2B3;
  localparam logic [31:0] B1 = 32'hC1C2_C3C4;

  typedef struct {
    logic [1:0]  rdy0, rdy1, gnt1, gnt2, done_v, done_after;
    logic        start1, early, err_v, rst_seen;
    logic [16:0] size1;
    logic [31:0] inA1, inA2, inB2, tiles_v;
  } job_obs_t;

  always #5 clk = ~clk;

  tensor_core_arbiter #(
    .NUM_REQ    (2),
    .MAX_SIZE   (64),
    .WDOG_LIMIT (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_size    (req_size),
    .req_inA     (req_inA),
    .req_inB     (req_inB),
    .gnt         (gnt),
    .done        (done),
    .err         (err),
    .tiles       (tiles),
    .core_start  (core_start),
    .core_size   (core_size),
    .core_inA    (core_inA),
    .core_inB    (core_inB),
    .core_valid  (core_valid),
    .core_push22 (core_push22),
    .core_reset  (core_reset)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_watch(inout job_obs_t o);
    tick();
    if (done != 2'b00 || gnt !== o.gnt2 || core_start) o.early = 1'b1;
    if (core_reset) o.rst_seen = 1'b1;
  endtask

  // Drives one full job (stimulus only) and records what the DUT showed.
  task automatic drive_job(input logic [1:0] vld, input int ntiles, input int clr_hold,
                           input bit push_last, output job_obs_t o);
    o.early = 1'b0;
    o.rst_seen = 1'b0;
    req_valid = vld;
    #1;
    o.rdy0 = req_ready;
    tick();
    req_valid = vld & ~o.rdy0;
    #1;
    o.rdy1 = req_ready;
    o.start1 = core_start;
    o.gnt1 = gnt;
    o.inA1 = core_inA;
    o.size1 = core_size;
    o.rst_seen = core_reset;
    tick();
    o.gnt2 = gnt;
    o.inA2 = core_inA;
    o.inB2 = core_inB;
    if (done != 2'b00) o.early = 1'b1;
    for (int i = 0; i < clr_hold; i++) wait_watch(o);
    core_valid = 1'b0;
    wait_watch(o);
    for (int i = 0; i < ntiles - int'(push_last); i++) begin
      core_push22 = 1'b1;
      wait_watch(o);
      core_push22 = 1'b0;
      wait_watch(o);
    end
    core_valid = 1'b1;
    core_push22 = push_last;
    tick();
    core_push22 = 1'b0;
    o.done_v = done;
    o.err_v = err;
    o.tiles_v = tiles;
    tick();
    o.done_after = done;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 2'b00;
    req_size = {17'd4, 17'd4};
    req_inA = {A1, A0};
    req_inB = {B1, B0};
    core_valid = 1'b0;
    core_push22 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL rst_core_reset got %b want 1", core_reset); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b want 00", gnt); end
    checks++; if (done !== 2'b00 || err !== 1'b0) begin errors++; $display("FAIL rst_done_err got %b/%b want 00/0", done, err); end
    checks++; if (tiles !== 32'd0 || core_size !== 17'd0) begin errors++; $display("FAIL rst_tiles_size got %0d/%0d want 0/0", tiles, core_size); end
    checks++; if (core_start !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL rst_start_ready got %b/%b want 0/00", core_start, req_ready); end
    checks++; if (core_inA !== 32'd0 || core_inB !== 32'd0) begin errors++; $display("FAIL rst_core_in got %h/%h want 0/0", core_inA, core_inB); end
    reset = 1'b1;
    tick();
    checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL rst_release_core_reset got %b want 0", core_reset); end
  endtask

  task automatic test_round_robin();
    job_obs_t o;
    drive_job(2'b11, 4, 0, 1'b0, o);
    checks++; if (o.rdy0 !== 2'b01) begin errors++; $display("FAIL rr1_ready got %b want 01", o.rdy0); end
    checks++; if (o.rdy1 !== 2'b00) begin errors++; $display("FAIL rr1_busy_ready got %b want 00", o.rdy1); end
    checks++; if (o.gnt2 !== 2'b01 || o.done_v !== 2'b01) begin errors++; $display("FAIL rr1_gnt_done got %b/%b want 01/01", o.gnt2, o.done_v); end
    drive_job(2'b11, 4, 1, 1'b0, o);
    checks++; if (o.rdy0 !== 2'b10) begin errors++; $display("FAIL rr2_ready got %b want 10", o.rdy0); end
    checks++; if (o.gnt2 !== 2'b10 || o.inA2 !== A1 || o.inB2 !== B1) begin errors++; $display("FAIL rr2_route got %b/%h/%h want 10/%h/%h", o.gnt2, o.inA2, o.inB2, A1, B1); end
    checks++; if (o.done_v !== 2'b10 || o.tiles_v !== 32'd4) begin errors++; $display("FAIL rr2_done got %b/%0d want 10/4", o.done_v, o.tiles_v); end
    drive_job(2'b11, 4, 1, 1'b0, o);
    checks++; if (o.rdy0 !== 2'b01 || o.done_v !== 2'b01) begin errors++; $display("FAIL rr3_ready_done got %b/%b want 01/01", o.rdy0, o.done_v); end
  endtask

  task automatic test_size4();
    job_obs_t o;
    req_size = {17'd4, 17'd4};
    drive_job(2'b01, 4, 1, 1'b0, o);
    checks++; if (o.start1 !== 1'b1 || o.gnt1 !== 2'b00 || o.inA1 !== 32'd0) begin errors++; $display("FAIL s4_cycle1 got start=%b gnt=%b inA=%h want 1/00/0", o.start1, o.gnt1, o.inA1); end
    checks++; if (o.size1 !== 17'd4) begin errors++; $display("FAIL s4_core_size got %0d want 4", o.size1); end
    checks++; if (o.gnt2 !== 2'b01 || o.inA2 !== A0 || o.inB2 !== B0) begin errors++; $display("FAIL s4_route got %b/%h/%h want 01/%h/%h", o.gnt2, o.inA2, o.inB2, A0, B0); end
    checks++; if (o.early !== 1'b0 || o.rst_seen !== 1'b0) begin errors++; $display("FAIL s4_wait got early=%b rst=%b want 0/0", o.early, o.rst_seen); end
    checks++; if (o.done_v !== 2'b01 || o.err_v !== 1'b0 || o.tiles_v !== 32'd4) begin errors++; $display("FAIL s4_resp got %b/%b/%0d want 01/0/4", o.done_v, o.err_v, o.tiles_v); end
    checks++; if (o.done_after !== 2'b00) begin errors++; $display("FAIL s4_done_pulse got %b want 00", o.done_after); end
  endtask

  task automatic test_size2_stale_valid();
    job_obs_t o;
    req_size = {17'd2, 17'd2};
    // core_valid is still high from the previous job and lingers 3 cycles
    drive_job(2'b01, 1, 3, 1'b1, o);
    checks++; if (o.early !== 1'b0) begin errors++; $display("FAIL s2_early got %b want 0", o.early); end
    checks++; if (o.done_v !== 2'b01 || o.err_v !== 1'b0 || o.tiles_v !== 32'd1) begin errors++; $display("FAIL s2_resp got %b/%b/%0d want 01/0/1", o.done_v, o.err_v, o.tiles_v); end
  endtask

  task automatic test_size_bounds();
    logic [16:0] bad [4];
    job_obs_t o;
    bad = '{17'd3, 17'd0, 17'h1FFFE, 17'd66};
    for (int i = 0; i < 4; i++) begin
      req_size[16:0] = bad[i];
      req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bad%0d_ready got %b want 01", i, req_ready); end
      tick();
      req_valid = 2'b00;
      checks++; if (done !== 2'b01 || err !== 1'b1 || tiles !== 32'd0) begin errors++; $display("FAIL bad%0d_resp got %b/%b/%0d want 01/1/0", i, done, err, tiles); end
      checks++; if (core_start !== 1'b0 || gnt !== 2'b00) begin errors++; $display("FAIL bad%0d_nostart got %b/%b want 0/00", i, core_start, gnt); end
      tick();
      checks++; if (done !== 2'b00 || core_start !== 1'b0) begin errors++; $display("FAIL bad%0d_after got %b/%b want 00/0", i, done, core_start); end
    end
    req_size[16:0] = 17'd64;
    drive_job(2'b01, 2, 1, 1'b0, o);
    checks++; if (o.start1 !== 1'b1 || o.size1 !== 17'd64) begin errors++; $display("FAIL max_start got %b/%0d want 1/64", o.start1, o.size1); end
    checks++; if (o.done_v !== 2'b01 || o.err_v !== 1'b0 || o.tiles_v !== 32'd2) begin errors++; $display("FAIL max_resp got %b/%b/%0d want 01/0/2", o.done_v, o.err_v, o.tiles_v); end
  endtask

  task automatic test_reset_midjob();
    job_obs_t o;
    logic saw_done;
    req_size = {17'd4, 17'd4};
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    core_valid = 1'b0;
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL mid_gnt got %b want 01", gnt); end
    core_push22 = 1'b1;
    tick();
    core_push22 = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (gnt !== 2'b00 || core_reset !== 1'b1) begin errors++; $display("FAIL mid_reset got gnt=%b core_reset=%b want 00/1", gnt, core_reset); end
    saw_done = (done != 2'b00);
    repeat (2) begin
      tick();
      if (done != 2'b00) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL mid_no_done got %b want 0", saw_done); end
    reset = 1'b1;
    tick();
    drive_job(2'b01, 4, 0, 1'b0, o);
    checks++; if (o.done_v !== 2'b01 || o.err_v !== 1'b0 || o.tiles_v !== 32'd4) begin errors++; $display("FAIL mid_recover got %b/%b/%0d want 01/0/4", o.done_v, o.err_v, o.tiles_v); end
  endtask

  task automatic test_watchdog();
    int rst_cyc;
    int done_cyc;
    logic dn_err;
    logic [31:0] dn_tiles;
    logic saw_rst;
    logic saw_done;
    rst_cyc = -1;
    done_cyc = -1;
    dn_err = 1'b0;
    dn_tiles = '0;
    saw_rst = 1'b0;
    saw_done = 1'b0;
    req_size = {17'd4, 17'd4};
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    core_valid = 1'b0;
`ifdef TENSOR_ARB_WDOG_EN
    for (int cyc = 2; cyc <= 60 && done_cyc < 0; cyc++) begin
      core_push22 = 1'b0;
      tick();
      if (cyc == 4 || cyc == 6) core_push22 = 1'b1;
      if (core_reset && rst_cyc < 0) rst_cyc = cyc;
      if (done != 2'b00) begin
        done_cyc = cyc;
        dn_err = err;
        dn_tiles = tiles;
      end
    end
    core_push22 = 1'b0;
    checks++; if (rst_cyc < 20 || rst_cyc > 23) begin errors++; $display("FAIL wdog_core_reset got cycle %0d want 20..23", rst_cyc); end
    checks++; if (done_cyc != rst_cyc + 1 || dn_err !== 1'b1 || dn_tiles !== 32'd2) begin errors++; $display("FAIL wdog_resp got cyc=%0d err=%b tiles=%0d want cyc=%0d err=1 tiles=2", done_cyc, dn_err, dn_tiles, rst_cyc + 1); end
    tick();
`else
    for (int cyc = 2; cyc <= 41; cyc++) begin
      tick();
      if (core_reset) saw_rst = 1'b1;
      if (done != 2'b00) saw_done = 1'b1;
    end
    checks++; if (saw_rst !== 1'b0 || saw_done !== 1'b0) begin errors++; $display("FAIL nowdog_hang got rst=%b done=%b want 0/0", saw_rst, saw_done); end
    core_valid = 1'b1;
    tick();
    checks++; if (done !== 2'b01 || err !== 1'b0 || tiles !== 32'd0) begin errors++; $display("FAIL nowdog_resp got %b/%b/%0d want 01/0/0", done, err, tiles); end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_size4();
    test_size2_stale_valid();
    test_size_bounds();
    test_reset_midjob();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
